// File: rtl/spi_mem_target.sv
// spi_mem_target: SPI mode-0 target (MSB first) backed by a small byte memory.
// Commands: 0x03 READ, 0x02 WRITE, 0x05 read status. All SPI pins are
// oversampled in the clk domain through 2-FF synchronizers.
// Optional feature macro: SPI_MEM_TARGET_WEL_EN adds a write-enable latch
// (0x06 WREN / 0x04 WRDI); without it writes are always accepted and WEL reads 0.
module spi_mem_target #(
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic busy,
  output logic cmd_err
);

  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [0:0] LAST_ADDR_BYTE = 1'(ADDR_W / 8 - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, READ, WRITE, STATUS, IGNORE
  } state_t;

  state_t            state;
  logic [1:0]        sck_sync, cs_sync, mosi_sync;
  logic              sck_prev, cs_prev;
  logic              sck_s, cs_s, mosi_s;
  logic              sck_rise, sck_fall, cs_rise, cs_fall;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_sr;
  logic [7:0]        rx_byte;
  logic [7:0]        tx_sr;
  logic              miso_bit;
  logic              byte_done;
  logic [IW-1:0]     addr;
  logic [ADDR_W-1:0] addr_full;
  logic [0:0]        ab_cnt;
  logic              is_read;
  logic [1:0]        load_pend;
  logic [7:0]        rd_data;
  logic              mem_we;
  logic [7:0]        status_byte;
  logic              wel;
  logic [7:0]        mem [MEM_DEPTH];

`ifdef SPI_MEM_TARGET_WEL_EN
  logic              wrote;
`else
  assign wel = 1'b0;
`endif

  // Address taken modulo the memory depth; bits above the range are ignored.
  function automatic logic [IW-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
    return IW'(32'(a) % 32'(MEM_DEPTH));
  endfunction

  function automatic logic [IW-1:0] next_addr(input logic [IW-1:0] a);
    return (a == IW'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign sck_s       = sck_sync[1];
  assign cs_s        = cs_sync[1];
  assign mosi_s      = mosi_sync[1];
  assign sck_rise    = sck_s & ~sck_prev;
  assign sck_fall    = ~sck_s & sck_prev;
  assign cs_rise     = cs_s & ~cs_prev;
  assign cs_fall     = ~cs_s & cs_prev;
  assign rx_byte     = {rx_sr, mosi_s};
  assign byte_done   = sck_rise && (bit_cnt == 3'd7);
  assign status_byte = {6'b0, wel, 1'b0};
  assign mem_we      = (state == WRITE) && byte_done && !cs_rise;
  assign spi_miso    = miso_bit & spi_miso_oe;

  // Synchronize the pins and keep one delayed copy for edge detection. The
  // cs_n chain resets low so a reset in the middle of a transaction never
  // produces a false cs_n fall: the next command needs a real cs_n fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b00;
      mosi_sync <= 2'b00;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_prev  <= sck_s;
      cs_prev   <= cs_s;
    end
  end

  // Assemble the address; the high byte only exists for 16-bit addressing.
  generate
    if (ADDR_W > 8) begin : g_addr_hi
      logic [ADDR_W-9:0] addr_hi;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          addr_hi <= '0;
        end else if (state == ADDR && byte_done && ab_cnt != LAST_ADDR_BYTE) begin
          addr_hi <= rx_byte[ADDR_W-9:0];
        end
      end
      assign addr_full = {addr_hi, rx_byte};
    end else begin : g_addr_lo
      assign addr_full = rx_byte;
    end
  endgenerate

  // Byte memory: synchronous write, registered read, no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr] <= rx_byte;
    end
    rd_data <= mem[addr];
  end

  // Bit shifting, command FSM and registered outputs. Memory reads take two
  // cycles (address settles, then registered read data), which is far inside
  // the minimum gap between an sck rise and the following fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      rx_sr       <= 7'd0;
      tx_sr       <= 8'd0;
      miso_bit    <= 1'b0;
      addr        <= '0;
      ab_cnt      <= 1'b0;
      is_read     <= 1'b0;
      load_pend   <= 2'd0;
      spi_miso_oe <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
`ifdef SPI_MEM_TARGET_WEL_EN
      wel         <= 1'b0;
      wrote       <= 1'b0;
`endif
    end else begin
      cmd_err <= 1'b0;
      if (sck_rise) begin
        rx_sr   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (sck_fall) begin
        miso_bit <= tx_sr[7];
        tx_sr    <= {tx_sr[6:0], 1'b0};
      end
      if (load_pend == 2'd1) begin
        load_pend <= 2'd2;
      end else if (load_pend == 2'd2) begin
        tx_sr     <= rd_data;
        addr      <= next_addr(addr);
        load_pend <= 2'd0;
      end

      if (cs_rise) begin
`ifdef SPI_MEM_TARGET_WEL_EN
        if (state == WRITE && wrote) begin
          wel <= 1'b0;
        end
`endif
        state       <= IDLE;
        spi_miso_oe <= 1'b0;
        busy        <= 1'b0;
        load_pend   <= 2'd0;
        miso_bit    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state    <= CMD;
              busy     <= 1'b1;
              bit_cnt  <= 3'd0;
              tx_sr    <= 8'd0;
              miso_bit <= 1'b0;
`ifdef SPI_MEM_TARGET_WEL_EN
              wrote    <= 1'b0;
`endif
            end
          end
          CMD: begin
            if (byte_done) begin
              case (rx_byte)
                8'h03: begin
                  state   <= ADDR;
                  is_read <= 1'b1;
                  ab_cnt  <= 1'b0;
                end
                8'h02: begin
`ifdef SPI_MEM_TARGET_WEL_EN
                  if (wel) begin
                    state   <= ADDR;
                    is_read <= 1'b0;
                    ab_cnt  <= 1'b0;
                  end else begin
                    state   <= IGNORE;
                  end
`else
                  state   <= ADDR;
                  is_read <= 1'b0;
                  ab_cnt  <= 1'b0;
`endif
                end
                8'h05: begin
                  state       <= STATUS;
                  tx_sr       <= status_byte;
                  spi_miso_oe <= 1'b1;
                end
`ifdef SPI_MEM_TARGET_WEL_EN
                8'h06: begin
                  wel   <= 1'b1;
                  state <= IGNORE;
                end
                8'h04: begin
                  wel   <= 1'b0;
                  state <= IGNORE;
                end
`endif
                default: begin
                  state   <= IGNORE;
                  cmd_err <= 1'b1;
                end
              endcase
            end
          end
          ADDR: begin
            if (byte_done) begin
              if (ab_cnt == LAST_ADDR_BYTE) begin
                addr <= wrap_addr(addr_full);
                if (is_read) begin
                  state       <= READ;
                  spi_miso_oe <= 1'b1;
                  load_pend   <= 2'd1;
                end else begin
                  state <= WRITE;
                end
              end else begin
                ab_cnt <= ab_cnt + 1'b1;
              end
            end
          end
          READ: begin
            if (byte_done) begin
              load_pend <= 2'd1;
            end
          end
          WRITE: begin
            if (byte_done) begin
              addr  <= next_addr(addr);
`ifdef SPI_MEM_TARGET_WEL_EN
              wrote <= 1'b1;
`endif
            end
          end
          STATUS: begin
            if (byte_done) begin
              tx_sr <= status_byte;
            end
          end
          IGNORE: begin
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_target.sv
// tb_spi_mem_target: drives SPI mode-0 transactions into spi_mem_target and
// compares read/status bytes against a scoreboard fed from a byte model.
`timescale 1ns/1ps
module tb_spi_mem_target;

  localparam int HALF = 5;  // clk periods per sck phase

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sck = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, busy, cmd_err;

  int n_checks = 0;
  int n_fail = 0;
  int err_pulses = 0;
  int oe_cycles = 0;
  int miso_leak = 0;

  logic [7:0] model [256];
  logic [7:0] exp_q [$];
  logic [7:0] wbuf [8];
  logic [7:0] rx_tmp;

  always #5 clk = ~clk;

  spi_mem_target #(.ADDR_W(8), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .busy(busy), .cmd_err(cmd_err)
  );

  always @(negedge clk) begin
    if (cmd_err) err_pulses++;
    if (spi_miso_oe) oe_cycles++;
    if (!spi_miso_oe && spi_miso) miso_leak++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (3) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Pop the oldest expected byte and compare with what came off MISO.
  task automatic score(input string tag, input logic [7:0] got);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, 32'(got), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(got), 32'(e));
    end
  endtask

  task automatic wren();
`ifdef SPI_MEM_TARGET_WEL_EN
    cs_low();
    xfer_bits(8'h06, 8, rx_tmp);
    cs_high();
`endif
  endtask

  task automatic write_txn(input logic [7:0] a, input int n);
    logic [7:0] ai;
    wren();
    cs_low();
    xfer_bits(8'h02, 8, rx_tmp);
    xfer_bits(a, 8, rx_tmp);
    for (int i = 0; i < n; i++) begin
      xfer_bits(wbuf[i], 8, rx_tmp);
      ai = a + 8'(i);
      model[ai] = wbuf[i];
    end
    cs_high();
    $display("txn write addr=%02h bytes=%0d", a, n);
  endtask

  task automatic read_txn(input logic [7:0] a, input int n);
    logic [7:0] ai;
    cs_low();
    xfer_bits(8'h03, 8, rx_tmp);
    xfer_bits(a, 8, rx_tmp);
    for (int i = 0; i < n; i++) begin
      ai = a + 8'(i);
      exp_q.push_back(model[ai]);
      xfer_bits(8'h00, 8, rx_tmp);
      score($sformatf("rd[%02h]", ai), rx_tmp);
    end
    cs_high();
  endtask

  task automatic status_txn(input logic [7:0] exp, input int n);
    cs_low();
    xfer_bits(8'h05, 8, rx_tmp);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp);
      xfer_bits(8'h00, 8, rx_tmp);
      score($sformatf("status%0d", i), rx_tmp);
    end
    cs_high();
  endtask

  initial begin
    int e0, o0;
    repeat (4) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_oe", 32'(spi_miso_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // write then read back, no command errors
    e0 = err_pulses;
    wbuf[0] = 8'hAA; wbuf[1] = 8'h55;
    write_txn(8'h10, 2);
    cs_low();
    check("busy_active", 32'(busy), 32'd1);
    xfer_bits(8'h03, 8, rx_tmp);
    xfer_bits(8'h10, 8, rx_tmp);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    xfer_bits(8'h00, 8, rx_tmp); score("rd_aa", rx_tmp);
    xfer_bits(8'h00, 8, rx_tmp); score("rd_55", rx_tmp);
    cs_high();
    check("busy_idle", 32'(busy), 32'd0);
    check("no_cmd_err", 32'(err_pulses - e0), 32'd0);

    // address wrap from FF to 00
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    write_txn(8'hFF, 2);
    read_txn(8'hFF, 2);
    exp_q.push_back(8'h22);
    cs_low();
    xfer_bits(8'h03, 8, rx_tmp);
    xfer_bits(8'h00, 8, rx_tmp);
    xfer_bits(8'h00, 8, rx_tmp);
    score("wrap_mem0", rx_tmp);
    cs_high();

    // partial byte is discarded
    wbuf[0] = 8'h00; wbuf[1] = 8'h00;
    write_txn(8'h20, 2);
    wren();
    cs_low();
    xfer_bits(8'h02, 8, rx_tmp);
    xfer_bits(8'h20, 8, rx_tmp);
    xfer_bits(8'hC3, 8, rx_tmp);
    xfer_bits(8'hF0, 4, rx_tmp);
    cs_high();
    model[8'h20] = 8'hC3;
    $display("txn partial write addr=20");
    read_txn(8'h20, 2);

    // unknown opcode: one cmd_err pulse, MISO never enabled
    e0 = err_pulses;
    o0 = oe_cycles;
    cs_low();
    xfer_bits(8'h9F, 8, rx_tmp);
    xfer_bits(8'h00, 8, rx_tmp);
    cs_high();
    check("unk_cmd_err", 32'(err_pulses - e0), 32'd1);
    check("unk_oe", 32'(oe_cycles - o0), 32'd0);

    // status repeats
    status_txn(8'h00, 2);

    // reset in the middle of a read data byte
    wbuf[0] = 8'h5A;
    write_txn(8'h40, 1);
    cs_low();
    xfer_bits(8'h03, 8, rx_tmp);
    xfer_bits(8'h40, 8, rx_tmp);
    xfer_bits(8'h00, 4, rx_tmp);
    check("oe_in_read", 32'(spi_miso_oe), 32'd1);
    check("partial_rd_bits", 32'(rx_tmp), 32'h5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_oe", 32'(spi_miso_oe), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_miso", 32'(spi_miso), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xfer_bits(8'h00, 4, rx_tmp);
    check("ignored_after_rst", 32'(busy), 32'd0);
    cs_high();
    status_txn(8'h00, 1);

`ifdef SPI_MEM_TARGET_WEL_EN
    e0 = err_pulses;
    wbuf[0] = 8'h00;
    write_txn(8'h30, 1);
    cs_low();
    xfer_bits(8'h02, 8, rx_tmp);
    xfer_bits(8'h30, 8, rx_tmp);
    xfer_bits(8'h77, 8, rx_tmp);
    cs_high();
    read_txn(8'h30, 1);
    cs_low();
    xfer_bits(8'h06, 8, rx_tmp);
    cs_high();
    status_txn(8'h02, 1);
    cs_low();
    xfer_bits(8'h02, 8, rx_tmp);
    xfer_bits(8'h30, 8, rx_tmp);
    xfer_bits(8'h77, 8, rx_tmp);
    cs_high();
    model[8'h30] = 8'h77;
    status_txn(8'h00, 1);
    read_txn(8'h30, 1);
    check("wel_no_cmd_err", 32'(err_pulses - e0), 32'd0);
`else
    // WREN/WRDI are unknown without the write-enable latch
    e0 = err_pulses;
    cs_low(); xfer_bits(8'h06, 8, rx_tmp); cs_high();
    cs_low(); xfer_bits(8'h04, 8, rx_tmp); cs_high();
    check("wren_unknown", 32'(err_pulses - e0), 32'd2);
    status_txn(8'h00, 1);
`endif

    check("miso_quiet", 32'(miso_leak), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_target.md
# spi_mem_target

SPI target (peripheral) front-end backed by a small on-chip byte memory. It is the far end of the serial link that the memory controller's serializer/deserializer drives, and it answers READ, WRITE and read-status commands. It serves as a flash/EEPROM stand-in for bring-up and as the controller's loopback partner in system simulation. SPI mode 0, MSB first, oversampled entirely in the `clk` domain.

## Interface
Parameters:
- `ADDR_W`, 8 — address width in bits; must be 8 or 16; address phase is `ADDR_W/8` bytes.
- `MEM_DEPTH`, 256 — memory size in bytes; must be ≤ 2**`ADDR_W`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `spi_sck`  in  1  SPI clock, asynchronous to `clk`, idle low.
- `spi_cs_n`  in  1  chip select, active low, asynchronous.
- `spi_mosi`  in  1  serial data from the initiator.
- `spi_miso`  out  1  serial data to the initiator.
- `spi_miso_oe`  out  1  output enable for the `spi_miso` pad.
- `busy`  out  1  high while a transaction is active (synced `cs_n` low).
- `cmd_err`  out  1  one-`clk` pulse when an unknown opcode is received.

## Operation
- `spi_sck`, `spi_cs_n` and `spi_mosi` each pass through a 2-FF synchronizer. Edge detect runs on the synced copies.
- `sck` rise: shift synced `mosi` into `rx_sr`, increment 3-bit `bit_cnt`. `sck` fall: `spi_miso <= tx_sr[7]`, then `tx_sr <= tx_sr << 1`.
- Byte boundary: `bit_cnt` wraps 7→0 on a rise. All state actions below occur on that same cycle.
- FSM states:
  - IDLE → CMD on synced `cs_n` fall. On entry, clear `bit_cnt` and `tx_sr`.
  - CMD: decode the opcode.
    - 0x03 → ADDR (read).
    - 0x02 → ADDR (write).
    - 0x05 → STATUS: load `tx_sr` with the status byte.
    - Any other opcode → IGNORE and pulse `cmd_err`.
  - ADDR: collect `ADDR_W/8` bytes MSB first, then go to READ or WRITE.
    - Read: on entry to READ, load `tx_sr <= mem[addr]` and set `addr <= addr+1`.
  - READ: each byte boundary loads `tx_sr <= mem[addr]` and sets `addr <= addr+1`.
  - WRITE: each byte boundary performs `mem[addr] <= rx_sr` and sets `addr <= addr+1`.
  - STATUS: each byte boundary reloads the status byte, so the status repeats.
  - IGNORE: no effect until `cs_n` rises.
  - Any state → IDLE on synced `cs_n` rise. A partial byte is discarded and not written.
- Address arithmetic: `addr` increments modulo `MEM_DEPTH`, so it wraps to 0 after `MEM_DEPTH-1`. Address bits above the range are ignored (taken modulo `MEM_DEPTH`).
- Status byte: {6'b0, WEL, WIP}. WIP is always 0.
- `spi_miso_oe` = 1 in READ and STATUS, 0 otherwise. `spi_miso` is 0 whenever `spi_miso_oe` is 0.
- Memory array is not reset. The bench must write a location before reading it.

## Timing
- Reset values: `spi_miso`=0, `spi_miso_oe`=0, `busy`=0, `cmd_err`=0, FSM=IDLE, `addr`=0, WEL=0.
- Input-pin to internal-edge latency: 3 `clk` (2 sync + 1 edge detect).
- Clock ratio: `spi_sck` high and low phases are each ≥ 4 `clk` periods, i.e. f_sck ≤ f_clk/8.
- `cs_n` fall to first `sck` rise: ≥ 4 `clk`.
- First read/status bit:
  - driven on the `sck` fall that follows the last command/address bit;
  - valid ≤ 4 `clk` after that fall;
  - the initiator samples it on the next rise.
- `busy` follows synced `cs_n` with 3 `clk` latency.
- `cmd_err` asserts the `clk` after the opcode's 8th rise.
- `rst` mid-transaction: immediate return to IDLE and reset values. The next command needs a fresh `cs_n` fall.

## Configuration
- `SPI_MEM_TARGET_WEL_EN` defined:
  - 0x06 (WREN) sets WEL; 0x04 (WRDI) clears it. Both then go to IGNORE.
  - A 0x02 WRITE with WEL=0 goes to IGNORE with no memory change and no `cmd_err`.
  - WEL clears on `cs_n` rise ending a WRITE that stored ≥1 byte.
- `SPI_MEM_TARGET_WEL_EN` undefined:
  - 0x06 and 0x04 are unknown opcodes and pulse `cmd_err`.
  - Writes are always accepted.
  - WEL reads as 0.

## Test plan
- Write then read, `ADDR_W`=8: send 02 10 AA 55, then 03 10 + 2 dummy bytes → MISO returns AA, 55; `cmd_err` stays 0.
- Wrap, `MEM_DEPTH`=256: send 02 FF 11 22, then 03 FF → returns 11 then 22; `mem[0]`=22.
- Partial byte: send 02 20 C3 followed by 4 bits, then raise `cs_n`. Read 03 20 → C3; location 21 is unchanged from its prior written value of 00.
- Unknown opcode 0x9F → `cmd_err` pulses once; `spi_miso_oe` stays 0 for the whole transaction.
- Reset mid-read: assert `rst` during a 03 data byte → `spi_miso_oe`=0 and `busy`=0 immediately. A subsequent 05 returns 00.
- With `SPI_MEM_TARGET_WEL_EN`: 02 30 77 without WREN → read returns the old value (00). Then 06, 05 → 02. Then 02 30 77, 05 → 00, and a read returns 77.
